// File: rtl/window_stats.sv
// ============================================================================
// window_stats
//
// Purpose
//   Collects fixed-size windows of 2**WINDOW_LOG2 accepted unsigned samples.
//   For each completed window it registers the exact sum, the floor mean,
//   the minimum and the maximum. It also pulses o_valid for one cycle.
//   Result outputs are held stable between windows.
//
// Parameters
//   DATA_W       sample width (unsigned)
//   WINDOW_LOG2  log2 of samples per window (1..8)
//
// Ports
//   i_clk     in   1                  clock, all logic on rising edge
//   i_rst     in   1                  synchronous active-high reset
//   i_sample  in   DATA_W             sample from the upstream select stage
//   i_valid   in   1                  i_sample accepted on this edge when 1
//   i_clear   in   1                  discard the partial window (sync)
//   o_sum     out  DATA_W+WINDOW_LOG2 exact window sum
//   o_mean    out  DATA_W             o_sum >> WINDOW_LOG2 (floor)
//   o_min     out  DATA_W             smallest sample of the last window
//   o_max     out  DATA_W             largest sample of the last window
//   o_valid   out  1                  one-cycle pulse when new results land
//   o_count   out  WINDOW_LOG2+1      samples held in the current partial window
// ============================================================================
module window_stats #(
    parameter int DATA_W      = 8,
    parameter int WINDOW_LOG2 = 3
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [DATA_W-1:0]             i_sample,
    input  logic                          i_valid,
    input  logic                          i_clear,
    output logic [DATA_W+WINDOW_LOG2-1:0] o_sum,
    output logic [DATA_W-1:0]             o_mean,
    output logic [DATA_W-1:0]             o_min,
    output logic [DATA_W-1:0]             o_max,
    output logic                          o_valid,
    output logic [WINDOW_LOG2:0]          o_count
);

    localparam int SUM_W = DATA_W + WINDOW_LOG2;
    localparam int CNT_W = WINDOW_LOG2 + 1;

    // Count value of the final sample in a window (window size minus one).
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << WINDOW_LOG2) - 1);

    localparam logic [SUM_W-1:0]  ACC_INIT = {SUM_W{1'b0}};
    localparam logic [DATA_W-1:0] MIN_INIT = {DATA_W{1'b1}};
    localparam logic [DATA_W-1:0] MAX_INIT = {DATA_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_INIT = {CNT_W{1'b0}};

    // ------------------------------------------------------------------
    // Running window state
    // ------------------------------------------------------------------
    logic [SUM_W-1:0]  acc_q,  acc_d;
    logic [DATA_W-1:0] rmin_q, rmin_d;
    logic [DATA_W-1:0] rmax_q, rmax_d;
    logic [CNT_W-1:0]  cnt_q,  cnt_d;

    // ------------------------------------------------------------------
    // Registered results
    // ------------------------------------------------------------------
    logic [SUM_W-1:0]  sum_q,   sum_d;
    logic [DATA_W-1:0] mean_q,  mean_d;
    logic [DATA_W-1:0] min_q,   min_d;
    logic [DATA_W-1:0] max_q,   max_d;
    logic              valid_q, valid_d;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic              accept_s;
    logic              last_s;
    logic [SUM_W-1:0]  acc_plus_s;
    logic [DATA_W-1:0] min_with_s;
    logic [DATA_W-1:0] max_with_s;

    // Clear has priority over a valid sample on the same edge.
    assign accept_s = i_valid & ~i_clear;
    assign last_s   = accept_s & (cnt_q == LAST_CNT);

    // The accumulator is wide enough for a full window of all-ones samples.
    // The addition therefore cannot overflow.
    assign acc_plus_s = acc_q + SUM_W'(i_sample);

    // Running extremes including the sample presented on this edge
    always_comb begin
        min_with_s = rmin_q;
        max_with_s = rmax_q;
        if (i_sample < rmin_q) begin
            min_with_s = i_sample;
        end else begin
            min_with_s = rmin_q;
        end
        if (i_sample > rmax_q) begin
            max_with_s = i_sample;
        end else begin
            max_with_s = rmax_q;
        end
    end

    // Next-state decode: clear, completing sample, ordinary sample, idle
    always_comb begin
        acc_d   = acc_q;
        rmin_d  = rmin_q;
        rmax_d  = rmax_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        mean_d  = mean_q;
        min_d   = min_q;
        max_d   = max_q;
        valid_d = 1'b0;

        if (i_clear) begin
            // Drop the partial window. The previous results stay visible.
            acc_d   = ACC_INIT;
            rmin_d  = MIN_INIT;
            rmax_d  = MAX_INIT;
            cnt_d   = CNT_INIT;
            valid_d = 1'b0;
        end else if (last_s) begin
            // Final sample: publish totals including this sample.
            // Rearm the window so the next sample can start immediately.
            sum_d   = acc_plus_s;
            mean_d  = acc_plus_s[SUM_W-1:WINDOW_LOG2];
            min_d   = min_with_s;
            max_d   = max_with_s;
            valid_d = 1'b1;
            acc_d   = ACC_INIT;
            rmin_d  = MIN_INIT;
            rmax_d  = MAX_INIT;
            cnt_d   = CNT_INIT;
        end else if (accept_s) begin
            acc_d   = acc_plus_s;
            rmin_d  = min_with_s;
            rmax_d  = max_with_s;
            cnt_d   = cnt_q + CNT_W'(1);
            valid_d = 1'b0;
        end else begin
            // Idle: everything holds and the pulse drops.
            valid_d = 1'b0;
        end
    end

    // State and result registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q   <= ACC_INIT;
            rmin_q  <= MIN_INIT;
            rmax_q  <= MAX_INIT;
            cnt_q   <= CNT_INIT;
            sum_q   <= {SUM_W{1'b0}};
            mean_q  <= {DATA_W{1'b0}};
            min_q   <= {DATA_W{1'b0}};
            max_q   <= {DATA_W{1'b0}};
            valid_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            rmin_q  <= rmin_d;
            rmax_q  <= rmax_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            mean_q  <= mean_d;
            min_q   <= min_d;
            max_q   <= max_d;
            valid_q <= valid_d;
        end
    end

    assign o_sum   = sum_q;
    assign o_mean  = mean_q;
    assign o_min   = min_q;
    assign o_max   = max_q;
    assign o_valid = valid_q;
    assign o_count = cnt_q;

endmodule

// File: tb/tb_window_stats.sv
// ============================================================================
// tb_window_stats
//
// Self-checking bench for window_stats (DATA_W=8, WINDOW_LOG2=3).
// A queue-based reference model of the accepted samples predicts every
// output. The outputs are compared on each falling edge. Directed tests
// also pin literal results right after the relevant rising edge.
// ============================================================================
module tb_window_stats;

    logic        clk;
    logic        rst;
    logic [7:0]  sample;
    logic        valid;
    logic        clear;
    logic [10:0] o_sum;
    logic [7:0]  o_mean;
    logic [7:0]  o_min;
    logic [7:0]  o_max;
    logic        o_valid;
    logic [3:0]  o_count;

    int n_vec;
    int n_err;

    window_stats #(.DATA_W(8), .WINDOW_LOG2(3)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_sample (sample),
        .i_valid  (valid),
        .i_clear  (clear),
        .o_sum    (o_sum),
        .o_mean   (o_mean),
        .o_min    (o_min),
        .o_max    (o_max),
        .o_valid  (o_valid),
        .o_count  (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: a list of the accepted samples in the current window
    // ------------------------------------------------------------------
    int   win_q[$];
    int   exp_sum, exp_mean, exp_min, exp_max, exp_valid, exp_count;
    bit   model_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            win_q.delete();
            exp_sum = 0; exp_mean = 0; exp_min = 0; exp_max = 0;
            exp_valid = 0;
            model_live = 1'b1;
        end else if (clear) begin
            win_q.delete();
            exp_valid = 0;
        end else if (valid) begin
            win_q.push_back(int'(sample));
            if (win_q.size() == 8) begin
                exp_sum = 0; exp_min = 255; exp_max = 0;
                foreach (win_q[k]) begin
                    exp_sum += win_q[k];
                    if (win_q[k] < exp_min) exp_min = win_q[k];
                    if (win_q[k] > exp_max) exp_max = win_q[k];
                end
                exp_mean  = exp_sum / 8;
                exp_valid = 1;
                win_q.delete();
            end else begin
                exp_valid = 0;
            end
        end else begin
            exp_valid = 0;
        end
        exp_count = win_q.size();
    end

    task automatic cmp(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (model_live) begin
            cmp("model.sum",   int'(o_sum),   exp_sum);
            cmp("model.mean",  int'(o_mean),  exp_mean);
            cmp("model.min",   int'(o_min),   exp_min);
            cmp("model.max",   int'(o_max),   exp_max);
            cmp("model.valid", int'(o_valid), exp_valid);
            cmp("model.count", int'(o_count), exp_count);
        end
    end

    // Drive one cycle. Outputs are observed 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] s, input logic c);
        valid  = v;
        sample = s;
        clear  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_res(input string name, input int v, input int sm,
                             input int mn, input int lo, input int hi);
        cmp({name, ".valid"}, int'(o_valid), v);
        cmp({name, ".sum"},   int'(o_sum),   sm);
        cmp({name, ".mean"},  int'(o_mean),  mn);
        cmp({name, ".min"},   int'(o_min),   lo);
        cmp({name, ".max"},   int'(o_max),   hi);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; valid = 1'b0; clear = 1'b0; sample = 8'd0;
        @(posedge clk); #1;
        step(1'b0, 8'd0, 1'b0);
        check_res("reset", 0, 0, 0, 0, 0);
        cmp("reset.count", int'(o_count), 0);
        rst = 1'b0;

        // 1: samples 1..8
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0);
        check_res("t1", 1, 36, 4, 1, 8);
        cmp("t1.count", int'(o_count), 0);
        step(1'b0, 8'd0, 1'b0);
        cmp("t1.pulse_end", int'(o_valid), 0);
        cmp("t1.hold_sum", int'(o_sum), 36);

        // 2: full-scale samples, no truncation
        for (int i = 0; i < 8; i++) step(1'b1, 8'd255, 1'b0);
        check_res("t2", 1, 2040, 255, 255, 255);

        // 3: valid on alternate cycles, count steps
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 8'd10, 1'b0);
            if (i < 8) begin
                cmp("t3.count", int'(o_count), i);
                cmp("t3.no_pulse", int'(o_valid), 0);
            end
            step(1'b0, 8'd99, 1'b0);
            if (i == 8) cmp("t3.pulse_once", int'(o_valid), 0);
        end
        check_res("t3", 0, 80, 10, 10, 10);

        // 4: partial window, clear with valid (clear wins), then 8 x 3
        for (int i = 0; i < 5; i++) step(1'b1, 8'd9, 1'b0);
        step(1'b1, 8'd200, 1'b1);
        check_res("t4.clear", 0, 80, 10, 10, 10);
        cmp("t4.count", int'(o_count), 0);
        for (int i = 0; i < 8; i++) step(1'b1, 8'd3, 1'b0);
        check_res("t4", 1, 24, 3, 3, 3);

        // Clear on the completing edge: no pulse, results held
        for (int i = 0; i < 7; i++) step(1'b1, 8'd50, 1'b0);
        step(1'b1, 8'd50, 1'b1);
        check_res("clr_last", 0, 24, 3, 3, 3);
        cmp("clr_last.count", int'(o_count), 0);

        // 5: partial window, reset, then 2,4,..,16
        for (int i = 0; i < 4; i++) step(1'b1, 8'd77, 1'b0);
        rst = 1'b1;
        step(1'b1, 8'd77, 1'b0);
        rst = 1'b0;
        check_res("t5.rst", 0, 0, 0, 0, 0);
        cmp("t5.rst_count", int'(o_count), 0);
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(2 * i), 1'b0);
        check_res("t5", 1, 72, 9, 2, 16);

        // 6: back-to-back windows 0..15
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i), 1'b0);
            if (i == 7)  check_res("t6a", 1, 28, 3, 0, 7);
            if (i == 8)  cmp("t6.gap", int'(o_valid), 0);
            if (i == 15) check_res("t6b", 1, 92, 11, 8, 15);
        end
        step(1'b0, 8'd0, 1'b0);
        step(1'b0, 8'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
